// File: rtl/tomasulo_pkg.sv
// ============================================================================
//  Module   : tomasulo_pkg
//  Brief    : Shared Tomasulo types: opcodes, CDB, issue payload, RS entries.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tomasulo_pkg;

    localparam int XLEN         = 32;
    localparam int TAG_W        = 6;
    localparam int ROB_W        = 5;
    localparam int REG_W        = 5;
    localparam int RS_N_DEFAULT = 4;

    typedef logic [XLEN-1:0]  word_t;
    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [ROB_W-1:0] robid_t;
    typedef logic [REG_W-1:0] regaddr_t;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SLL = 4'd5,
        OP_SRL = 4'd6,
        OP_SLT = 4'd7
    } opcode_t;

    typedef struct packed {
        logic     vld;
        tag_t     tag;
        word_t    wdata;
        robid_t   robid;
        regaddr_t wa;
    } cdb_t;

    typedef struct packed {
        opcode_t     op;
        tag_t        tag;
        robid_t      robid;
        regaddr_t    wa;
        word_t [1:0] rdata;
    } issue_t;

    typedef struct packed {
        logic  rdy;
        tag_t  tag;
        word_t data;
    } rs_src_t;

    typedef struct packed {
        opcode_t       op;
        tag_t          tag;
        robid_t        robid;
        regaddr_t      wa;
        rs_src_t [1:0] src;
    } rs_disp_t;

    // A pending operand is satisfied by a broadcast carrying its producer tag.
    function automatic logic src_hit(input rs_src_t s, input cdb_t c);
        return c.vld && !s.rdy && (s.tag == c.tag);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tomasulo_age_matrix.sv
// ============================================================================
//  Module   : tomasulo_age_matrix
//  Brief    : Age matrix picking the oldest requester among N slots.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tomasulo_age_matrix #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic [N-1:0] alloc,
    input  logic [N-1:0] free,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    // r_age[i][j] set means slot j is older than slot i.
    logic [N-1:0] r_age [N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                r_age[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < N; i++) begin
                r_age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    // A newly allocated slot is younger than everyone, so its
                    // column is cleared as well as on free.
                    if (alloc[j] || free[j]) begin
                        r_age[i][j] <= 1'b0;
                    end else if (alloc[i]) begin
                        r_age[i][j] <= 1'b1;
                    end
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_gnt
            assign gnt[gi] = req[gi] && !(|(r_age[gi] & req));
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/tomasulo_rs_arith.sv
// ============================================================================
//  Module   : tomasulo_rs_arith
//  Brief    : Arithmetic reservation station with CDB wakeup and oldest-first
//             issue. Optional macro TOMASULO_RS_WAKEUP_BYPASS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tomasulo_rs_arith
    import tomasulo_pkg::*;
#(
    parameter int N     = RS_N_DEFAULT,
    parameter int SRC_N = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   disp_vld,
    input  rs_disp_t               disp,
    output logic                   disp_rdy,
    input  cdb_t                   cdb,
    input  logic                   iss_busy,
    output logic                   iss_vld_r,
    output issue_t                 iss_r,
    output logic [$clog2(N+1)-1:0] occ_r
);

    localparam int c_occ_w = $clog2(N+1);

    logic [N-1:0]     r_vld;
    rs_disp_t         r_ent [N];

    logic [SRC_N-1:0] w_hit [N];
    logic [SRC_N-1:0] w_srdy [N];
    logic [N-1:0]     w_rdy;
    logic [N-1:0]     w_gnt;
    logic [N-1:0]     w_alloc;
    logic [N-1:0]     w_free;
    logic             w_found;
    logic             w_acc;
    logic             w_iss_en;
    logic             w_any;
    issue_t           w_iss_pl;
    rs_disp_t         w_new;
    logic             w_unused_cdb;

    assign w_unused_cdb = ^{cdb.robid, cdb.wa};

    assign disp_rdy = (occ_r != c_occ_w'(N));
    assign w_acc    = disp_vld && disp_rdy && !flush;
    assign w_iss_en = !iss_busy || !iss_vld_r;
    assign w_any    = |w_rdy;
    assign w_free   = (w_iss_en && !flush) ? w_gnt : '0;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int s = 0; s < SRC_N; s++) begin
                w_hit[i][s]  = src_hit(r_ent[i].src[s], cdb);
`ifdef TOMASULO_RS_WAKEUP_BYPASS_EN
                w_srdy[i][s] = r_ent[i].src[s].rdy || w_hit[i][s];
`else
                w_srdy[i][s] = r_ent[i].src[s].rdy;
`endif
            end
            w_rdy[i] = r_vld[i] && (&w_srdy[i]);
        end
    end

    always_comb begin
        w_alloc = '0;
        w_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!r_vld[i] && !w_found) begin
                w_alloc[i] = w_acc;
                w_found    = 1'b1;
            end
        end
    end

    // Dispatching operands also snoop this cycle's broadcast.
    always_comb begin
        w_new = disp;
        for (int s = 0; s < SRC_N; s++) begin
            if (src_hit(disp.src[s], cdb)) begin
                w_new.src[s].rdy  = 1'b1;
                w_new.src[s].data = cdb.wdata;
            end
        end
    end

    always_comb begin
        w_iss_pl = '0;
        for (int i = 0; i < N; i++) begin
            if (w_gnt[i]) begin
                w_iss_pl.op    = r_ent[i].op;
                w_iss_pl.tag   = r_ent[i].tag;
                w_iss_pl.robid = r_ent[i].robid;
                w_iss_pl.wa    = r_ent[i].wa;
                for (int s = 0; s < SRC_N; s++) begin
`ifdef TOMASULO_RS_WAKEUP_BYPASS_EN
                    w_iss_pl.rdata[s] = w_hit[i][s] ? cdb.wdata : r_ent[i].src[s].data;
`else
                    w_iss_pl.rdata[s] = r_ent[i].src[s].data;
`endif
                end
            end
        end
    end

    tomasulo_age_matrix #(
        .N     (N)
    ) u_age (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .alloc (w_alloc),
        .free  (w_free),
        .req   (w_rdy),
        .gnt   (w_gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int i = 0; i < N; i++) begin
                r_ent[i] <= '0;
            end
        end else if (flush) begin
            r_vld <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (w_alloc[i]) begin
                    r_vld[i] <= 1'b1;
                    r_ent[i] <= w_new;
                end else begin
                    if (w_free[i]) begin
                        r_vld[i] <= 1'b0;
                    end
                    for (int s = 0; s < SRC_N; s++) begin
                        if (r_vld[i] && w_hit[i][s]) begin
                            r_ent[i].src[s].rdy  <= 1'b1;
                            r_ent[i].src[s].data <= cdb.wdata;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_vld_r <= 1'b0;
            iss_r     <= '0;
            occ_r     <= '0;
        end else if (flush) begin
            iss_vld_r <= 1'b0;
            iss_r     <= '0;
            occ_r     <= '0;
        end else begin
            if (w_iss_en) begin
                iss_vld_r <= w_any;
                iss_r     <= w_iss_pl;
            end
            occ_r <= occ_r + c_occ_w'(w_acc) - c_occ_w'(|w_free);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tomasulo_rs_arith.sv
// ============================================================================
//  Module   : tb_tomasulo_rs_arith
//  Brief    : Scoreboard bench for the arithmetic reservation station.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tomasulo_rs_arith;
    import tomasulo_pkg::*;

`ifdef TOMASULO_RS_WAKEUP_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic     clk = 1'b0;
    logic     rst_n;
    logic     flush;
    logic     disp_vld;
    rs_disp_t disp;
    logic     disp_rdy;
    cdb_t     cdb;
    logic     iss_busy;
    logic     iss_vld_r;
    issue_t   iss_r;
    logic [2:0] occ_r;

    int n_cmp = 0;
    int n_bad = 0;
    issue_t sb_q [$];
    logic sv_vld  = 1'b0;
    logic sv_busy = 1'b0;

    tomasulo_rs_arith #(.N(4), .SRC_N(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .disp_vld  (disp_vld),
        .disp      (disp),
        .disp_rdy  (disp_rdy),
        .cdb       (cdb),
        .iss_busy  (iss_busy),
        .iss_vld_r (iss_vld_r),
        .iss_r     (iss_r),
        .occ_r     (occ_r)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic rs_disp_t mk(input opcode_t op, input tag_t tg,
                                    input logic r0, input tag_t t0, input word_t d0,
                                    input logic r1, input tag_t t1, input word_t d1);
        rs_disp_t d;
        d.op    = op;
        d.tag   = tg;
        d.robid = tg[4:0];
        d.wa    = tg[4:0] + 5'd1;
        d.src[0] = '{rdy: r0, tag: t0, data: d0};
        d.src[1] = '{rdy: r1, tag: t1, data: d1};
        return d;
    endfunction

    function automatic issue_t exp_of(input rs_disp_t d, input word_t v0, input word_t v1);
        issue_t e;
        e.op       = d.op;
        e.tag      = d.tag;
        e.robid    = d.robid;
        e.wa       = d.wa;
        e.rdata[0] = v0;
        e.rdata[1] = v1;
        return e;
    endfunction

    // One-shot inputs apply to exactly one edge.
    task automatic tick();
        @(posedge clk);
        #1;
        disp_vld = 1'b0;
        cdb      = '0;
        flush    = 1'b0;
    endtask

    task automatic bcast(input tag_t tg, input word_t v);
        cdb = '{vld: 1'b1, tag: tg, wdata: v, robid: 5'd0, wa: 5'd0};
    endtask

    task automatic send(input rs_disp_t d);
        disp     = d;
        disp_vld = 1'b1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        check("drain", 128'(sb_q.size()), 128'd0);
        tick();
    endtask

    // A new issue is one loaded at an edge where the output was free to move.
    always @(negedge clk) begin
        issue_t e;
        if (iss_vld_r && (!sv_vld || !sv_busy)) begin
            if (sb_q.size() == 0) begin
                check("sb_extra", 128'd1, 128'd0);
            end else begin
                e = sb_q.pop_front();
                check("sb_issue", 128'(iss_r), 128'(e));
            end
        end
        sv_vld  = iss_vld_r && rst_n;
        sv_busy = iss_busy;
    end

    initial begin
        rs_disp_t a, b, p, q, r;
        issue_t   e1, e2;

        rst_n = 1'b0; flush = 1'b0; disp_vld = 1'b0; disp = '0; cdb = '0; iss_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_vld", 128'(iss_vld_r), 128'd0);
        check("rst_occ", 128'(occ_r), 128'd0);
        check("rst_rdy", 128'(disp_rdy), 128'd1);
        check("rst_iss", 128'(iss_r), 128'd0);
        rst_n = 1'b1;
        tick();

        // Fully ready op: issue one edge after accept.
        a = mk(OP_ADD, 6'd1, 1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 32'd7);
        send(a); sb_q.push_back(exp_of(a, 32'd5, 32'd7));
        tick();
        check("t1_occ_acc", 128'(occ_r), 128'd1);
        check("t1_vld_e0", 128'(iss_vld_r), 128'd0);
        tick();
        check("t1_vld_e1", 128'(iss_vld_r), 128'd1);
        check("t1_rdata", 128'(iss_r.rdata), {64'd0, 32'd7, 32'd5});
        check("t1_occ_e1", 128'(occ_r), 128'd0);
        tick();

        // Younger ready op overtakes an older waiting one.
        a = mk(OP_SUB, 6'd2, 1'b1, 6'd0, 32'd1, 1'b0, 6'd3, 32'hDEAD);
        b = mk(OP_XOR, 6'd4, 1'b1, 6'd0, 32'd2, 1'b1, 6'd0, 32'd4);
        send(a); tick();
        send(b); sb_q.push_back(exp_of(b, 32'd2, 32'd4)); tick();
        tick();
        check("t2_b_vld", 128'(iss_vld_r), 128'd1);
        tick();
        check("t2_idle", 128'(iss_vld_r), 128'd0);
        bcast(6'd3, 32'h10); sb_q.push_back(exp_of(a, 32'd1, 32'h10));
        tick();
        check("t2_wake_e", 128'(iss_vld_r), 128'(BYP));
        tick();
        check("t2_wake_e1", 128'(iss_vld_r), 128'(!BYP));
        wait_drain();

        // Wakeup arriving in the dispatch cycle must be captured.
        a = mk(OP_AND, 6'd5, 1'b0, 6'd9, 32'hDEAD, 1'b1, 6'd0, 32'h33);
        send(a); bcast(6'd9, 32'h2A); sb_q.push_back(exp_of(a, 32'h2A, 32'h33));
        tick();
        check("t3_occ", 128'(occ_r), 128'd1);
        tick();
        check("t3_vld", 128'(iss_vld_r), 128'd1);
        wait_drain();

        // Fill, reject a fifth, then wake all together.
        for (int k = 0; k < 4; k++) begin
            send(mk(OP_OR, 6'(10 + k), 1'b1, 6'd0, 32'(100 + k), 1'b0, 6'd12, 32'hBAD));
            tick();
        end
        check("t4_full_rdy", 128'(disp_rdy), 128'd0);
        check("t4_full_occ", 128'(occ_r), 128'd4);
        send(mk(OP_ADD, 6'd20, 1'b1, 6'd0, 32'd9, 1'b1, 6'd0, 32'd9));
        tick();
        check("t4_reject", 128'(occ_r), 128'd4);
        for (int k = 0; k < 4; k++) begin
            sb_q.push_back(exp_of(mk(OP_OR, 6'(10 + k), 1'b1, 6'd0, 32'(100 + k), 1'b0, 6'd12, 32'hBAD),
                                  32'(100 + k), 32'h12C));
        end
        bcast(6'd12, 32'h12C);
        tick();
        tick();
        check("t4_rdy_free", 128'(disp_rdy), 128'd1);
        wait_drain();

        // Younger entry in a lower slot must still issue after the older one.
        p = mk(OP_SLL, 6'd21, 1'b0, 6'd20, 32'd0, 1'b1, 6'd0, 32'd3);
        q = mk(OP_SRL, 6'd22, 1'b0, 6'd31, 32'd0, 1'b1, 6'd0, 32'd4);
        r = mk(OP_SLT, 6'd23, 1'b0, 6'd31, 32'd0, 1'b1, 6'd0, 32'd5);
        send(p); tick();
        send(q); tick();
        bcast(6'd20, 32'h20); sb_q.push_back(exp_of(p, 32'h20, 32'd3)); tick();
        wait_drain();
        send(r); tick();
        sb_q.push_back(exp_of(q, 32'h31, 32'd4));
        sb_q.push_back(exp_of(r, 32'h31, 32'd5));
        bcast(6'd31, 32'h31); tick();
        wait_drain();

        // Back-pressure holds the issued payload.
        a = mk(OP_ADD, 6'd24, 1'b1, 6'd0, 32'd11, 1'b1, 6'd0, 32'd12);
        b = mk(OP_SUB, 6'd25, 1'b1, 6'd0, 32'd13, 1'b1, 6'd0, 32'd14);
        e1 = exp_of(a, 32'd11, 32'd12);
        e2 = exp_of(b, 32'd13, 32'd14);
        send(a); sb_q.push_back(e1); tick();
        send(b); sb_q.push_back(e2); tick();
        iss_busy = 1'b1;
        check("t5_vld", 128'(iss_vld_r), 128'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t5_hold_iss", 128'(iss_r), 128'(e1));
            check("t5_hold_vld", 128'(iss_vld_r), 128'd1);
            check("t5_hold_occ", 128'(occ_r), 128'd1);
        end
        iss_busy = 1'b0;
        tick();
        check("t5_release", 128'(iss_r), 128'(e2));
        check("t5_occ0", 128'(occ_r), 128'd0);
        wait_drain();

        // Flush kills entries, the held issue and a same-cycle dispatch.
        a = mk(OP_XOR, 6'd26, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd2);
        send(a); sb_q.push_back(exp_of(a, 32'd1, 32'd2)); tick();
        send(mk(OP_ADD, 6'd27, 1'b0, 6'd40, 32'd0, 1'b1, 6'd0, 32'd0)); tick();
        iss_busy = 1'b1;
        send(mk(OP_ADD, 6'd28, 1'b0, 6'd41, 32'd0, 1'b1, 6'd0, 32'd0)); tick();
        send(mk(OP_ADD, 6'd29, 1'b0, 6'd42, 32'd0, 1'b1, 6'd0, 32'd0)); tick();
        check("t6_pre_occ", 128'(occ_r), 128'd3);
        check("t6_pre_vld", 128'(iss_vld_r), 128'd1);
        flush = 1'b1;
        send(mk(OP_AND, 6'd30, 1'b1, 6'd0, 32'd7, 1'b1, 6'd0, 32'd7));
        tick();
        check("t6_occ", 128'(occ_r), 128'd0);
        check("t6_vld", 128'(iss_vld_r), 128'd0);
        check("t6_rdy", 128'(disp_rdy), 128'd1);
        iss_busy = 1'b0;
        bcast(6'd40, 32'd1); tick();
        bcast(6'd41, 32'd1); tick();
        bcast(6'd42, 32'd1); tick();
        tick(); tick();
        check("t6_no_issue", 128'(iss_vld_r), 128'd0);
        check("t6_occ_end", 128'(occ_r), 128'd0);

        // Asynchronous reset mid-operation.
        send(mk(OP_OR, 6'd31, 1'b0, 6'd43, 32'd0, 1'b1, 6'd0, 32'd0)); tick();
        send(mk(OP_OR, 6'd32, 1'b0, 6'd44, 32'd0, 1'b1, 6'd0, 32'd0)); tick();
        check("t7_occ_pre", 128'(occ_r), 128'd2);
        #2 rst_n = 1'b0;
        #1;
        check("t7_occ_rst", 128'(occ_r), 128'd0);
        check("t7_rdy_rst", 128'(disp_rdy), 128'd1);
        tick();
        rst_n = 1'b1;
        bcast(6'd43, 32'd1); tick();
        bcast(6'd44, 32'd1); tick();
        tick(); tick();
        check("t7_no_issue", 128'(iss_vld_r), 128'd0);
        check("sb_empty", 128'(sb_q.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
